// File: rtl/spu_pkg.sv
// spu_pkg: shared state type and width helpers for the SPU event arbiter
package spu_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, PRESENT = 1'b1} spu_arb_state_e;
  function automatic int spu_evt_w(input int num_event);
    return (num_event > 1) ? $clog2(num_event) : 1;
  endfunction
  function automatic int spu_idx_w(input int num_source);
    return (num_source > 1) ? $clog2(num_source) : 1;
  endfunction
endpackage

// File: rtl/spu_arb_rr.sv
// spu_arb_rr: combinational round-robin pick, searching upward from the pointer with wrap
module spu_arb_rr
  import spu_pkg::*;
#(
  parameter int NUM_SOURCE = 4,
  parameter int SRC_W = spu_idx_w(NUM_SOURCE)
) (
  input  logic [NUM_SOURCE-1:0] i_req,
  input  logic [SRC_W-1:0]      i_ptr,
  output logic [SRC_W-1:0]      o_gnt,
  output logic                  o_any
);
  logic [SRC_W-1:0] w_idx;
  always_comb begin
    o_gnt = '0;
    o_any = 1'b0;
    w_idx = '0;
    for (int k = 0; k < NUM_SOURCE; k++) begin
      w_idx = SRC_W'((int'(i_ptr) + k) % NUM_SOURCE);
      if (!o_any && i_req[w_idx]) begin
        o_gnt = w_idx;
        o_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/spu_event_arbiter.sv
// spu_event_arbiter: per-source one-entry holding registers feeding a round-robin output register.
// Drop counters exist only when SPU_ARB_DROP_CNT_EN is defined; otherwise drop_cnt_o is tied to 0.
module spu_event_arbiter
  import spu_pkg::*;
#(
  parameter int NUM_SOURCE      = 4,
  parameter int NUM_EVENT       = 5,
  parameter int EVENT_INFO_BITS = 8,
  parameter int CNT_WIDTH       = 8,
  localparam int EVT_W = spu_evt_w(NUM_EVENT),
  localparam int SRC_W = spu_idx_w(NUM_SOURCE)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_SOURCE-1:0]                 src_valid_i,
  input  logic [NUM_SOURCE*EVT_W-1:0]           src_event_i,
  input  logic [NUM_SOURCE*EVENT_INFO_BITS-1:0] src_info_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [SRC_W-1:0]                      out_src_o,
  output logic [EVT_W-1:0]                      out_event_o,
  output logic [EVENT_INFO_BITS-1:0]            out_info_o,
  input  logic                                  drop_clr_i,
  output logic [NUM_SOURCE*CNT_WIDTH-1:0]       drop_cnt_o
);
  logic [NUM_SOURCE-1:0]      r_hold_valid;
  logic [EVT_W-1:0]           r_hold_evt [NUM_SOURCE];
  logic [EVENT_INFO_BITS-1:0] r_hold_info [NUM_SOURCE];
  spu_arb_state_e             r_state;
  logic [SRC_W-1:0]           r_rr_ptr;
  logic [SRC_W-1:0]           r_out_src;
  logic [EVT_W-1:0]           r_out_evt;
  logic [EVENT_INFO_BITS-1:0] r_out_info;
  logic [SRC_W-1:0]           w_gnt;
  logic                       w_any;
  logic                       w_take;
  logic [NUM_SOURCE-1:0]      w_drain;
  logic [NUM_SOURCE-1:0]      w_load;

  spu_arb_rr #(.NUM_SOURCE(NUM_SOURCE), .SRC_W(SRC_W)) u_rr (
    .i_req (r_hold_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_any (w_any)
  );

  // The output register accepts a new grant when empty or when its current entry is handshaking.
  assign w_take  = w_any && (r_state == IDLE || out_ready_i);
  assign w_drain = w_take ? (NUM_SOURCE'(1) << w_gnt) : '0;
  assign w_load  = src_valid_i & (~r_hold_valid | w_drain);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_hold_valid <= '0;
    else r_hold_valid <= (r_hold_valid & ~w_drain) | src_valid_i;
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_SOURCE; i++) begin
      if (w_load[i]) begin
        r_hold_evt[i]  <= src_event_i[i*EVT_W +: EVT_W];
        r_hold_info[i] <= src_info_i[i*EVENT_INFO_BITS +: EVENT_INFO_BITS];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_out_src  <= '0;
      r_out_evt  <= '0;
      r_out_info <= '0;
    end else if (w_take) begin
      r_state    <= PRESENT;
      r_rr_ptr   <= (w_gnt == SRC_W'(NUM_SOURCE - 1)) ? '0 : w_gnt + 1'b1;
      r_out_src  <= w_gnt;
      r_out_evt  <= r_hold_evt[w_gnt];
      r_out_info <= r_hold_info[w_gnt];
    end else if (out_ready_i) begin
      r_state <= IDLE;
    end
  end

  assign out_valid_o = (r_state == PRESENT);
  assign out_src_o   = r_out_src;
  assign out_event_o = r_out_evt;
  assign out_info_o  = r_out_info;

`ifdef SPU_ARB_DROP_CNT_EN
  logic [NUM_SOURCE-1:0] w_drop;
  logic [CNT_WIDTH-1:0]  r_drop_cnt [NUM_SOURCE];
  assign w_drop = src_valid_i & r_hold_valid & ~w_drain;
  always_ff @(posedge clk_i) begin
    if (rst_i || drop_clr_i) r_drop_cnt <= '{default: '0};
    else
      for (int i = 0; i < NUM_SOURCE; i++)
        if (w_drop[i] && r_drop_cnt[i] != '1) r_drop_cnt[i] <= r_drop_cnt[i] + 1'b1;
  end
  for (genvar g = 0; g < NUM_SOURCE; g++) begin : g_cnt
    assign drop_cnt_o[g*CNT_WIDTH +: CNT_WIDTH] = r_drop_cnt[g];
  end
`else
  logic w_unused_clr;
  assign w_unused_clr = drop_clr_i;
  assign drop_cnt_o   = '0;
`endif
endmodule

// File: tb/tb_spu_event_arbiter.sv
// tb_spu_event_arbiter: directed checks of grant order, latency, drops, refill and reset
module tb_spu_event_arbiter;
  localparam int NS = 4, EW = 3, IW = 8, CW = 2;
`ifdef SPU_ARB_DROP_CNT_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, ready = 1'b1, clr = 1'b0;
  logic [NS-1:0] src_valid = '0;
  logic [NS*EW-1:0] src_event = '0;
  logic [NS*IW-1:0] src_info = '0;
  logic out_valid;
  logic [1:0] out_src;
  logic [EW-1:0] out_event;
  logic [IW-1:0] out_info;
  logic [NS*CW-1:0] drop_cnt;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  spu_event_arbiter #(.NUM_SOURCE(NS), .NUM_EVENT(5), .EVENT_INFO_BITS(IW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst), .src_valid_i(src_valid), .src_event_i(src_event),
    .src_info_i(src_info), .out_valid_o(out_valid), .out_ready_i(ready),
    .out_src_o(out_src), .out_event_o(out_event), .out_info_o(out_info),
    .drop_clr_i(clr), .drop_cnt_o(drop_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int v, input int s, input int e, input int inf);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_src"}, 32'(out_src), 32'(s));
    chk({tag, "_event"}, 32'(out_event), 32'(e));
    chk({tag, "_info"}, 32'(out_info), 32'(inf));
  endtask

  task automatic pulse(input int s, input int ev, input int inf);
    src_valid[s] = 1'b1;
    src_event[s*EW +: EW] = EW'(ev);
    src_info[s*IW +: IW] = IW'(inf);
  endtask

  function automatic logic [31:0] dc(input logic [31:0] v);
    return CE ? v : 32'd0;
  endfunction

  initial begin
    tick; tick;
    chk_out("reset", 0, 0, 0, 0);
    chk("reset_drop", 32'(drop_cnt), 0);
    rst = 1'b0;
    pulse(2, 3, 'hA5); tick; src_valid = '0;
    chk("single_lat", 32'(out_valid), 0);
    tick;
    chk_out("single", 1, 2, 3, 'hA5);
    chk("single_drop", 32'(drop_cnt), 0);
    tick;
    chk("single_idle", 32'(out_valid), 0);
    rst = 1'b1; tick; rst = 1'b0;
    for (int s = 0; s < NS; s++) pulse(s, s, 'h10 + s);
    tick; src_valid = '0;
    for (int s = 0; s < NS; s++) begin
      tick;
      chk_out("fair", 1, s, s, 'h10 + s);
    end
    tick;
    chk("fair_idle", 32'(out_valid), 0);
    ready = 1'b0;
    pulse(1, 1, 'h31); tick; src_valid = '0; tick;
    chk_out("bp_present", 1, 1, 1, 'h31);
    pulse(1, 2, 'h32); tick;
    pulse(1, 3, 'h33); tick;
    pulse(1, 4, 'h34); tick; src_valid = '0;
    for (int c = 0; c < 5; c++) tick;
    chk_out("bp_stable", 1, 1, 1, 'h31);
    chk("bp_drop", 32'(drop_cnt), dc('h08));
    ready = 1'b1; tick;
    chk_out("bp_next", 1, 1, 2, 'h32);
    tick;
    chk("bp_idle", 32'(out_valid), 0);
    ready = 1'b0;
    pulse(0, 0, 'h40); tick; src_valid = '0; tick;
    chk_out("sat_present", 1, 0, 0, 'h40);
    pulse(0, 1, 'h41); tick;
    pulse(0, 2, 'h50); tick; tick; tick;
    chk("sat_3", 32'(drop_cnt), dc('h0B));
    tick; tick; tick;
    chk("sat_6", 32'(drop_cnt), dc('h0B));
    clr = 1'b1; tick; clr = 1'b0;
    chk("clr_vs_drop", 32'(drop_cnt), 0);
    tick; src_valid = '0;
    chk("after_clr", 32'(drop_cnt), dc('h01));
    chk_out("sat_stable", 1, 0, 0, 'h40);
    ready = 1'b1;
    pulse(0, 2, 'h42); tick; src_valid = '0;
    chk_out("refill_drain", 1, 0, 1, 'h41);
    chk("refill_nodrop", 32'(drop_cnt), dc('h01));
    tick;
    chk_out("refill_new", 1, 0, 2, 'h42);
    tick;
    chk("refill_idle", 32'(out_valid), 0);
    ready = 1'b0;
    pulse(1, 1, 'h61); pulse(2, 2, 'h62); pulse(3, 3, 'h63);
    tick; src_valid = '0; tick;
    chk_out("rp_present", 1, 1, 1, 'h61);
    pulse(0, 0, 'h60); tick; src_valid = '0;
    pulse(2, 4, 'h64); tick; src_valid = '0;
    chk("rp_drop", 32'(drop_cnt), dc('h11));
    rst = 1'b1; src_valid = '1; tick;
    rst = 1'b0; src_valid = '0;
    chk_out("rp_reset", 0, 0, 0, 0);
    chk("rp_reset_drop", 32'(drop_cnt), 0);
    tick;
    chk("rp_empty", 32'(out_valid), 0);
    pulse(3, 3, 'h73); pulse(2, 2, 'h72); tick; src_valid = '0; tick;
    chk_out("rp_first", 1, 2, 2, 'h72);
    ready = 1'b1; tick;
    chk_out("rp_second", 1, 3, 3, 'h73);
    tick;
    chk("rp_idle", 32'(out_valid), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
